// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
//
// Sequencing controller for the stopwatch digit-counter chain. Raw button
// levels are synchronized and turned into single-cycle press events, which
// drive an IDLE/RUN/PAUSE/LAP state machine. The controller enables, holds and
// clears the counter chain, produces the prescaled count tick, and gives the
// display mux a lap-capture strobe plus a display-freeze flag.
//
// Parameters
//   TICK_DIV     clk cycles per count tick (legal 2 .. 2**DIV_W-1)
//   DIV_W        prescaler counter width
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   btn_start    raw start/resume button level (asynchronous)
//   btn_stop     raw stop button level (asynchronous)
//   btn_lap      raw lap/split button level (asynchronous)
//   btn_clear    raw clear button level (asynchronous)
//   start_resume count enable to counter chain (RUN or LAP)
//   stop         hold request to counter chain (PAUSE)
//   cnt_clear    one-cycle clear pulse to counter chain
//   tick         one-cycle count pulse to least-significant counter
//   lap_load     one-cycle strobe, display latch captures current count
//   disp_freeze  display shows latched lap value (LAP)
//   state        IDLE=00, RUN=01, PAUSE=10, LAP=11
// -----------------------------------------------------------------------------
module stopwatch_controller #(
   parameter int TICK_DIV = 10000,
   parameter int DIV_W    = 14
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_stop,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic       start_resume,
   output logic       stop,
   output logic       cnt_clear,
   output logic       tick,
   output logic       lap_load,
   output logic       disp_freeze,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_e;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   // Button bit positions inside the packed event vectors
   localparam int B_START = 0;
   localparam int B_STOP  = 1;
   localparam int B_LAP   = 2;
   localparam int B_CLEAR = 3;

   logic [3:0]       btn_raw_s;
   logic [3:0]       sync1_q;
   logic [3:0]       sync2_q;
   logic [3:0]       hist_q;
   logic [3:0]       ev_s;

   state_e           state_q;
   state_e           state_d;
   logic             clr_d;
   logic             lap_d;

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             tick_d;
   logic             run_now_s;
   logic             run_next_s;

   logic             start_resume_q;
   logic             stop_q;
   logic             cnt_clear_q;
   logic             tick_q;
   logic             lap_load_q;
   logic             disp_freeze_q;

   assign btn_raw_s = {btn_clear, btn_lap, btn_stop, btn_start};

   // Synchronizer and edge history. Reset to 1 so a button already held
   // when reset releases looks "old" and produces no event until re-pressed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         hist_q  <= 4'hF;
      end else begin
         sync1_q <= btn_raw_s;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   // One event per press: synchronized level high, previous level low
   assign ev_s = sync2_q & ~hist_q;

   // Next-state decode. Within each state only legal events are considered,
   // tested in priority order clear > stop > start > lap, so the highest
   // legal one wins and the rest are dropped.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      lap_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ev_s[B_CLEAR]) begin
               clr_d = 1'b1;
            end else if (ev_s[B_START]) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ev_s[B_STOP] || ev_s[B_START]) begin
               state_d = ST_PAUSE;
            end else if (ev_s[B_LAP]) begin
               state_d = ST_LAP;
               lap_d   = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_LAP: begin
            if (ev_s[B_CLEAR]) begin
               // Unfreeze only; the counters keep running untouched
               state_d = ST_RUN;
            end else if (ev_s[B_STOP] || ev_s[B_START]) begin
               state_d = ST_PAUSE;
            end else if (ev_s[B_LAP]) begin
               lap_d = 1'b1;
            end else begin
               state_d = ST_LAP;
            end
         end
         ST_PAUSE: begin
            if (ev_s[B_CLEAR]) begin
               state_d = ST_IDLE;
               clr_d   = 1'b1;
            end else if (ev_s[B_START]) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign run_now_s  = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign run_next_s = (state_d == ST_RUN) || (state_d == ST_LAP);

   // Prescaler. It only advances on edges where the chain is counting both
   // before and after, so the edge entering PAUSE and the edge leaving it
   // both hold the count: a tick due on the pause edge is deferred to after
   // resume rather than lost or duplicated.
   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      if (clr_d || (state_d == ST_IDLE)) begin
         div_d = '0;
      end else if (run_now_s && run_next_s) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end else begin
         div_d = div_q;
      end
   end

   // State machine register with outputs decoded from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         div_q          <= '0;
         start_resume_q <= 1'b0;
         stop_q         <= 1'b0;
         cnt_clear_q    <= 1'b0;
         tick_q         <= 1'b0;
         lap_load_q     <= 1'b0;
         disp_freeze_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         div_q          <= div_d;
         start_resume_q <= run_next_s;
         stop_q         <= (state_d == ST_PAUSE);
         cnt_clear_q    <= clr_d;
         tick_q         <= tick_d;
         lap_load_q     <= lap_d;
         disp_freeze_q  <= (state_d == ST_LAP);
      end
   end

   assign start_resume = start_resume_q;
   assign stop         = stop_q;
   assign cnt_clear    = cnt_clear_q;
   assign tick         = tick_q;
   assign lap_load     = lap_load_q;
   assign disp_freeze  = disp_freeze_q;
   assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
//
// Directed scenarios followed by randomized button activity. Every cycle the
// full output vector is compared with a behavioural model that works from
// sampled button history, press events and an elapsed-count modulo TICK_DIV.
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;

   localparam int TICK_DIV = 4;
   localparam int DIV_W    = 4;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   logic       clk;
   logic       reset;
   logic       btn_start;
   logic       btn_stop;
   logic       btn_lap;
   logic       btn_clear;
   logic       start_resume;
   logic       stop;
   logic       cnt_clear;
   logic       tick;
   logic       lap_load;
   logic       disp_freeze;
   logic [1:0] state;
   logic [7:0] obs_s;

   int         n_chk;
   int         n_bad;
   logic [7:0] tick_seen;

   // reference model state
   logic [1:0] m_state;
   int         m_elapsed;
   logic [3:0] m_h0;
   logic [3:0] m_h1;
   logic [3:0] m_h2;
   logic [7:0] m_vec;

   logic [3:0] rb;

   stopwatch_controller #(
      .TICK_DIV (TICK_DIV),
      .DIV_W    (DIV_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_start    (btn_start),
      .btn_stop     (btn_stop),
      .btn_lap      (btn_lap),
      .btn_clear    (btn_clear),
      .start_resume (start_resume),
      .stop         (stop),
      .cnt_clear    (cnt_clear),
      .tick         (tick),
      .lap_load     (lap_load),
      .disp_freeze  (disp_freeze),
      .state        (state)
   );

   assign obs_s = {state, start_resume, stop, cnt_clear, tick, lap_load, disp_freeze};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state   = S_IDLE;
      m_elapsed = 0;
      m_h0      = 4'hF;
      m_h1      = 4'hF;
      m_h2      = 4'hF;
      m_vec     = 8'h00;
   endtask

   // One rising edge of the reference: b is the level sampled at this edge.
   // A press acts two edges after it is first sampled high.
   task automatic model_edge(input logic [3:0] b);
      logic [3:0] ev;
      logic [1:0] nxt;
      logic       clr;
      logic       lap;
      logic       tk;
      logic       run_now;
      logic       run_nxt;
      ev   = m_h1 & ~m_h2;
      m_h2 = m_h1;
      m_h1 = m_h0;
      m_h0 = b;
      nxt  = m_state;
      clr  = 1'b0;
      lap  = 1'b0;
      tk   = 1'b0;
      // bit0 start, bit1 stop, bit2 lap, bit3 clear
      if (m_state == S_IDLE) begin
         if (ev[3]) clr = 1'b1;
         else if (ev[0]) nxt = S_RUN;
      end else if (m_state == S_RUN) begin
         if (ev[1] || ev[0]) nxt = S_PAUSE;
         else if (ev[2]) begin nxt = S_LAP; lap = 1'b1; end
      end else if (m_state == S_LAP) begin
         if (ev[3]) nxt = S_RUN;
         else if (ev[1] || ev[0]) nxt = S_PAUSE;
         else if (ev[2]) lap = 1'b1;
      end else begin
         if (ev[3]) begin nxt = S_IDLE; clr = 1'b1; end
         else if (ev[0]) nxt = S_RUN;
      end
      run_now = (m_state == S_RUN) || (m_state == S_LAP);
      run_nxt = (nxt == S_RUN) || (nxt == S_LAP);
      if (nxt == S_IDLE) begin
         m_elapsed = 0;
      end else if (run_now && run_nxt) begin
         m_elapsed = m_elapsed + 1;
         if ((m_elapsed % TICK_DIV) == 0) tk = 1'b1;
      end
      m_state = nxt;
      m_vec   = {nxt, run_nxt, (nxt == S_PAUSE), clr, tk, lap, (nxt == S_LAP)};
   endtask

   // Drive buttons, let one edge happen, check outputs on the falling edge
   task automatic cyc(input logic [3:0] b);
      {btn_clear, btn_lap, btn_stop, btn_start} = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
      chk("outs", obs_s, m_vec);
      if (tick === 1'b1) tick_seen = tick_seen + 8'd1;
   endtask

   task automatic cycn(input logic [3:0] b, input int n);
      for (int i = 0; i < n; i++) cyc(b);
   endtask

   // 1-unit reset pulse placed between clock edges
   task automatic pulse_reset();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_rst", obs_s, 8'h00);
      reset = 1'b1;
   endtask

   initial begin
      n_chk     = 0;
      n_bad     = 0;
      tick_seen = 8'd0;
      rb        = 4'h0;
      reset     = 1'b0;
      {btn_clear, btn_lap, btn_stop, btn_start} = 4'b0001;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_outs", obs_s, 8'h00);
      reset = 1'b1;

      // start held through reset: no event
      cycn(4'b0001, 20);
      chk("held_idle", {6'b0, state}, 8'h00);
      cycn(4'b0000, 2);
      cyc(4'b0001);
      cyc(4'b0001);
      chk("latency_k1", {6'b0, state}, 8'h00);
      cyc(4'b0001);
      chk("latency_k2", {6'b0, state}, 8'h01);

      // free running: one tick every TICK_DIV edges
      tick_seen = 8'd0;
      cycn(4'b0001, 20);
      chk("tick_cnt", tick_seen, 8'd5);
      chk("run_en", {6'b0, start_resume, stop}, 8'h02);

      // pause with two cycles of the prescaler consumed
      cycn(4'b0010, 3);
      chk("paused", {6'b0, state}, 8'h02);
      tick_seen = 8'd0;
      cycn(4'b0000, 10);
      chk("pause_tick", tick_seen, 8'd0);
      chk("pause_stop", {7'b0, stop}, 8'h01);
      cycn(4'b0001, 3);
      chk("resumed", {6'b0, state}, 8'h01);
      cyc(4'b0001);
      chk("resume_t1", {7'b0, tick}, 8'h00);
      cyc(4'b0001);
      chk("resume_t2", {7'b0, tick}, 8'h01);

      // lap, second lap, clear unfreezes
      cycn(4'b0000, 2);
      cycn(4'b0100, 3);
      chk("lap1", {state, lap_load, disp_freeze}, 8'h0F);
      cycn(4'b0000, 2);
      cycn(4'b0100, 3);
      chk("lap2", {state, lap_load, disp_freeze}, 8'h0F);
      cycn(4'b0000, 2);
      cycn(4'b1000, 3);
      chk("lap_clear", {state, disp_freeze, cnt_clear}, 8'h04);

      // pause, then clear and start together
      cycn(4'b0000, 2);
      cycn(4'b0010, 3);
      chk("pause2", {6'b0, state}, 8'h02);
      cycn(4'b0000, 2);
      cycn(4'b1001, 3);
      chk("clr_wins", {5'b0, state, cnt_clear}, 8'h01);
      cyc(4'b0000);
      chk("clr_pulse", {7'b0, cnt_clear}, 8'h00);

      // clear ignored while running
      cycn(4'b0001, 3);
      chk("run_again", {6'b0, state}, 8'h01);
      cycn(4'b0000, 2);
      cycn(4'b1000, 3);
      chk("clr_in_run", {5'b0, state, cnt_clear}, 8'h02);

      // asynchronous reset in the middle of RUN
      cycn(4'b0000, 3);
      pulse_reset();

      // randomized activity with occasional asynchronous resets
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
         end
         if ($urandom_range(0, 399) == 0) pulse_reset();
         cyc(rb);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
